// File: rtl/wb_decoder.sv
// rtl/wb_decoder.sv - Wishbone B4 pipelined address decoder and bus guard
//
// Routes one controller transfer at a time to one of N_PERI peripherals,
// selected by the top SEL_W address bits. An unmapped index, or a peripheral
// that never acks within TIMEOUT cycles, ends the transfer with wbc_err.
// All wbc_* outputs are decoded from registered state only.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wbc_cyc/stb/we/adr/dat_w controller request side (in)
//   wbc_stall/ack/err/dat_r  controller response side (out)
//   wbp_cyc/stb              per-peripheral cycle and strobe (out)
//   wbp_we/adr/dat_w         shared peripheral request fields (out)
//   wbp_stall/ack/dat_r      per-peripheral responses (in)

module wb_decoder #(
    parameter int N_PERI  = 4,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wbc_cyc,
    input  logic                       wbc_stb,
    input  logic                       wbc_we,
    input  logic [ADDR_W-1:0]          wbc_adr,
    input  logic [DATA_W-1:0]          wbc_dat_w,
    output logic                       wbc_stall,
    output logic                       wbc_ack,
    output logic                       wbc_err,
    output logic [DATA_W-1:0]          wbc_dat_r,
    output logic [N_PERI-1:0]          wbp_cyc,
    output logic [N_PERI-1:0]          wbp_stb,
    output logic                       wbp_we,
    output logic [ADDR_W-SEL_W-1:0]    wbp_adr,
    output logic [DATA_W-1:0]          wbp_dat_w,
    input  logic [N_PERI-1:0]          wbp_stall,
    input  logic [N_PERI-1:0]          wbp_ack,
    input  logic [N_PERI*DATA_W-1:0]   wbp_dat_r
);

    localparam int PADR_W = ADDR_W - SEL_W;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    // One extra bit so that N_PERI == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   N_PERI_LIM = (SEL_W + 1)'(N_PERI);
    // Counter value in the last cycle before the TIMEOUT count is reached.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                capture;

    logic [SEL_W-1:0]    idx_q;
    logic                we_q;
    logic [PADR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_w_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [SEL_W-1:0]    adr_idx;
    logic                accept;
    logic                timed_out;
    logic                sel_ack;
    logic                sel_stall;
    logic [DATA_W-1:0]   sel_dat;

    assign adr_idx   = wbc_adr[ADDR_W-1 -: SEL_W];
    assign accept    = (state == S_IDLE) && wbc_cyc && wbc_stb;
    assign timed_out = (cnt_q == CNT_LAST);

    // Select the addressed peripheral's responses. The loop only spans the
    // mapped ports, so an unmapped index never reads outside wbp_dat_r.
    always_comb begin
        sel_ack   = 1'b0;
        sel_stall = 1'b0;
        sel_dat   = '0;
        for (int i = 0; i < N_PERI; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ack   = wbp_ack[i];
                sel_stall = wbp_stall[i];
                sel_dat   = wbp_dat_r[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort (controller drops cyc) beats everything; an ack in the final
    // counted cycle beats the timeout.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wbc_cyc && wbc_stb) begin
                    state_nxt = ({1'b0, adr_idx} >= N_PERI_LIM) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (!wbc_cyc) begin
                    state_nxt = S_IDLE;
                end else if (!sel_stall && sel_ack) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                end else if (!sel_stall) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wbc_cyc) begin
                    state_nxt = S_IDLE;
                end else if (sel_ack) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_w_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                idx_q   <= adr_idx;
                we_q    <= wbc_we;
                adr_q   <= wbc_adr[PADR_W-1:0];
                dat_w_q <= wbc_dat_w;
                cnt_q   <= '0;
            end else if (state == S_REQ || state == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                rdata_q <= sel_dat;
            end
        end
    end

    always_comb begin
        wbp_cyc = '0;
        wbp_stb = '0;
        for (int i = 0; i < N_PERI; i++) begin
            if (idx_q == SEL_W'(i)) begin
                wbp_cyc[i] = (state == S_REQ) || (state == S_WAIT);
                wbp_stb[i] = (state == S_REQ);
            end
        end
    end

    assign wbp_we    = we_q;
    assign wbp_adr   = adr_q;
    assign wbp_dat_w = dat_w_q;

    assign wbc_stall = (state != S_IDLE);
    assign wbc_ack   = (state == S_DONE);
    assign wbc_err   = (state == S_ERR);
    assign wbc_dat_r = (state == S_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_wb_decoder.sv
// tb/tb_wb_decoder.sv - directed self-checking bench for wb_decoder

module tb_wb_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_cyc, a_stb, a_we;
    logic [7:0]  a_adr, a_dat_w;
    logic        a_stall, a_ack, a_err;
    logic [7:0]  a_dat_r;
    logic [3:0]  a_pcyc, a_pstb;
    logic        a_pwe;
    logic [5:0]  a_padr;
    logic [7:0]  a_pdat_w;
    logic [3:0]  a_pstall, a_pack;
    logic [31:0] a_pdat_r;

    logic        b_cyc, b_stb, b_we;
    logic [7:0]  b_adr, b_dat_w;
    logic        b_stall, b_ack, b_err;
    logic [7:0]  b_dat_r;
    logic [2:0]  b_pcyc, b_pstb;
    logic        b_pwe;
    logic [5:0]  b_padr;
    logic [7:0]  b_pdat_w;
    logic [2:0]  b_pstall, b_pack;
    logic [23:0] b_pdat_r;

    int checks = 0;
    int failures = 0;
    int stb_n, ack_n, err_n, ack_k, err_k, stall_lo;

    wb_decoder #(.N_PERI(4), .SEL_W(2), .ADDR_W(8), .DATA_W(8), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .rst(rst),
        .wbc_cyc(a_cyc), .wbc_stb(a_stb), .wbc_we(a_we), .wbc_adr(a_adr), .wbc_dat_w(a_dat_w),
        .wbc_stall(a_stall), .wbc_ack(a_ack), .wbc_err(a_err), .wbc_dat_r(a_dat_r),
        .wbp_cyc(a_pcyc), .wbp_stb(a_pstb), .wbp_we(a_pwe), .wbp_adr(a_padr), .wbp_dat_w(a_pdat_w),
        .wbp_stall(a_pstall), .wbp_ack(a_pack), .wbp_dat_r(a_pdat_r)
    );

    wb_decoder #(.N_PERI(3), .SEL_W(2), .ADDR_W(8), .DATA_W(8), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .wbc_cyc(b_cyc), .wbc_stb(b_stb), .wbc_we(b_we), .wbc_adr(b_adr), .wbc_dat_w(b_dat_w),
        .wbc_stall(b_stall), .wbc_ack(b_ack), .wbc_err(b_err), .wbc_dat_r(b_dat_r),
        .wbp_cyc(b_pcyc), .wbp_stb(b_pstb), .wbp_we(b_pwe), .wbp_adr(b_padr), .wbp_dat_w(b_pdat_w),
        .wbp_stall(b_pstall), .wbp_ack(b_pack), .wbp_dat_r(b_pdat_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_cyc = 0; a_stb = 0; a_we = 0; a_adr = '0; a_dat_w = '0;
        a_pstall = '0; a_pack = '0; a_pdat_r = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_dat_w = '0;
        b_pstall = '0; b_pack = '0; b_pdat_r = '0;

        tick();
        tick();
        chk("rst_stall", a_stall, 0);
        chk("rst_ack", a_ack, 0);
        chk("rst_err", a_err, 0);
        chk("rst_dat_r", a_dat_r, 0);
        chk("rst_pcyc", a_pcyc, 0);
        chk("rst_pstb", a_pstb, 0);
        chk("rst_pwe", a_pwe, 0);
        chk("rst_padr", a_padr, 0);
        chk("rst_b_pcyc", b_pcyc, 0);
        rst = 1'b1;
        tick();

        // Zero-wait read of peripheral 1
        a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 8'h43;
        chk("rd_idle_stall", a_stall, 0);
        tick();
        chk("rd_pstb", a_pstb, 4'b0010);
        chk("rd_pcyc", a_pcyc, 4'b0010);
        chk("rd_padr", a_padr, 6'h03);
        chk("rd_req_stall", a_stall, 1);
        chk("rd_early_ack", a_ack, 0);
        a_stb = 0; a_pack = 4'b0010; a_pdat_r[15:8] = 8'h5A;
        tick();
        chk("rd_ack", a_ack, 1);
        chk("rd_dat_r", a_dat_r, 8'h5A);
        chk("rd_done_pcyc", a_pcyc, 0);
        chk("rd_done_stall", a_stall, 1);
        a_pack = '0; a_cyc = 0;
        tick();
        chk("rd_after_ack", a_ack, 0);
        chk("rd_after_stall", a_stall, 0);
        chk("rd_after_dat_r", a_dat_r, 0);

        // Stalled write to peripheral 3; peripheral 0 acks continuously and must be ignored
        a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 8'hC7; a_dat_w = 8'h99; a_pdat_r = 32'h11223344;
        stb_n = 0; ack_n = 0; err_n = 0; ack_k = 0; stall_lo = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (a_pstb[3]) stb_n++;
            if (a_ack) begin ack_n++; ack_k = k; end
            if (a_err) err_n++;
            if (k <= 7 && !a_stall) stall_lo++;
            if (k == 1) begin
                chk("wr_pwe", a_pwe, 1);
                chk("wr_pdat_w", a_pdat_w, 8'h99);
                chk("wr_padr", a_padr, 6'h07);
                chk("wr_pcyc", a_pcyc, 4'b1000);
            end
            a_stb = 0;
            a_pstall = (k <= 3) ? 4'b1000 : 4'b0000;
            a_pack = (k == 6) ? 4'b1000 : 4'b0001;
            if (k == 7) a_cyc = 0;
        end
        chk("wr_stb_cycles", stb_n, 4);
        chk("wr_ack_count", ack_n, 1);
        chk("wr_ack_cycle", ack_k, 7);
        chk("wr_err_count", err_n, 0);
        chk("wr_stall_low", stall_lo, 0);
        a_pack = '0; a_pstall = '0; a_we = 0;

        // Abort in WAIT followed by a late ack
        a_cyc = 1; a_stb = 1; a_adr = 8'h85;
        ack_n = 0; err_n = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (a_ack) ack_n++;
            if (a_err) err_n++;
            if (k == 2) begin
                chk("ab_wait_pcyc", a_pcyc, 4'b0100);
                chk("ab_wait_pstb", a_pstb, 0);
            end
            if (k == 3) begin
                chk("ab_idle_pcyc", a_pcyc, 0);
                chk("ab_idle_stall", a_stall, 0);
            end
            a_stb = 0;
            if (k == 2) a_cyc = 0;
            a_pack = (k == 4) ? 4'b0100 : 4'b0000;
        end
        chk("ab_ack_count", ack_n, 0);
        chk("ab_err_count", err_n, 0);
        a_cyc = 1; a_stb = 1; a_adr = 8'h21;
        tick();
        chk("ab_p0_pstb", a_pstb, 4'b0001);
        chk("ab_p0_padr", a_padr, 6'h21);
        a_stb = 0; a_pack = 4'b0001; a_pdat_r[7:0] = 8'h3C;
        tick();
        chk("ab_p0_ack", a_ack, 1);
        chk("ab_p0_dat_r", a_dat_r, 8'h3C);
        a_pack = '0; a_cyc = 0;
        tick();
        chk("ab_p0_ack_clear", a_ack, 0);

        // Reset asserted mid-WAIT
        a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 8'h4F; a_dat_w = 8'h66;
        tick();
        a_stb = 0;
        tick();
        chk("rs_wait_pcyc", a_pcyc, 4'b0010);
        chk("rs_wait_padr", a_padr, 6'h0F);
        #2 rst = 1'b0;
        #1;
        chk("rs_pcyc", a_pcyc, 0);
        chk("rs_stall", a_stall, 0);
        chk("rs_padr", a_padr, 0);
        chk("rs_pdat_w", a_pdat_w, 0);
        chk("rs_pwe", a_pwe, 0);
        a_cyc = 0; a_we = 0;
        tick();
        rst = 1'b1;
        a_cyc = 1; a_stb = 1; a_adr = 8'h80;
        tick();
        chk("rs_p2_pstb", a_pstb, 4'b0100);
        a_stb = 0; a_pack = 4'b0100; a_pdat_r[23:16] = 8'hA5;
        tick();
        chk("rs_p2_ack", a_ack, 1);
        chk("rs_p2_dat_r", a_dat_r, 8'hA5);
        a_pack = '0; a_cyc = 0;
        tick();

        // Unmapped index on the 3-peripheral instance
        b_cyc = 1; b_stb = 1; b_adr = 8'hC0;
        tick();
        chk("um_err", b_err, 1);
        chk("um_ack", b_ack, 0);
        chk("um_pcyc", b_pcyc, 0);
        chk("um_pstb", b_pstb, 0);
        b_stb = 0; b_cyc = 0;
        tick();
        chk("um_err_clear", b_err, 0);
        chk("um_pcyc_after", b_pcyc, 0);

        // Timeout: peripheral 1 never acks
        b_cyc = 1; b_stb = 1; b_adr = 8'h41;
        err_n = 0; err_k = 0; ack_n = 0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (b_err) begin err_n++; err_k = k; end
            if (b_ack) ack_n++;
            if (k == 8) chk("to_pcyc_held", b_pcyc, 3'b010);
            if (k == 9) chk("to_pcyc_drop", b_pcyc, 3'b000);
            b_stb = 0;
            if (k == 9) b_cyc = 0;
        end
        chk("to_err_count", err_n, 1);
        chk("to_err_cycle", err_k, 9);
        chk("to_ack_count", ack_n, 0);

        // Ack in the final counted cycle wins over the timeout
        b_cyc = 1; b_stb = 1; b_adr = 8'h41; b_pdat_r[15:8] = 8'hE1;
        err_n = 0; ack_n = 0; ack_k = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (b_err) err_n++;
            if (b_ack) begin
                ack_n++; ack_k = k;
                chk("tw_dat_r", b_dat_r, 8'hE1);
            end
            b_stb = 0;
            b_pack = (k == 8) ? 3'b010 : 3'b000;
            if (k == 9) b_cyc = 0;
        end
        chk("tw_ack_count", ack_n, 1);
        chk("tw_ack_cycle", ack_k, 9);
        chk("tw_err_count", err_n, 0);

        // Normal transfer after timeout handling
        b_cyc = 1; b_stb = 1; b_adr = 8'h80;
        tick();
        chk("nx_pstb", b_pstb, 3'b100);
        b_stb = 0; b_pack = 3'b100; b_pdat_r[23:16] = 8'h77;
        tick();
        chk("nx_ack", b_ack, 1);
        chk("nx_dat_r", b_dat_r, 8'h77);
        b_pack = '0; b_cyc = 0;
        tick();
        chk("nx_ack_clear", b_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
